// File: rtl/gpr_wb_arbiter.sv
// Register-file write-back arbiter: round-robin between ALU and load unit,
// one registered GPR write per cycle, plus a pending-load scoreboard for decode stalls.
module gpr_wb_arbiter #(
    parameter int WordSize = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                alu_valid,
    input  logic [4:0]          alu_rd,
    input  logic [WordSize-1:0] alu_data,
    output logic                alu_ready,
    input  logic                lsu_valid,
    input  logic [4:0]          lsu_rd,
    input  logic [WordSize-1:0] lsu_data,
    output logic                lsu_ready,
    input  logic                issue_en,
    input  logic [4:0]          issue_rd,
    input  logic [4:0]          chk_rs1n,
    input  logic [4:0]          chk_rs2n,
    input  logic [4:0]          chk_rdn,
    output logic                stall,
    output logic                wbe,
    output logic [4:0]          rdn,
    output logic [WordSize-1:0] rdd
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

    grant_e                last_q, last_d;
    logic                  wbe_q, wbe_d;
    logic [4:0]            rdn_q, rdn_d;
    logic [WordSize-1:0]   rdd_q, rdd_d;
    logic [31:0]           busy_q, busy_d;
    logic                  alu_grant_s;
    logic                  lsu_grant_s;

    // Grant selection: a tie goes to whoever did not win the last transfer
    always_comb begin
        alu_grant_s = 1'b0;
        lsu_grant_s = 1'b0;
        if (alu_valid && lsu_valid) begin
            if (last_q == GRANT_LSU) begin
                alu_grant_s = 1'b1;
            end else begin
                lsu_grant_s = 1'b1;
            end
        end else begin
            alu_grant_s = alu_valid;
            lsu_grant_s = lsu_valid;
        end
    end

    assign alu_ready = alu_grant_s;
    assign lsu_ready = lsu_grant_s;

    // Next-state for write port, last-grant and scoreboard
    always_comb begin
        last_d = last_q;
        wbe_d  = 1'b0;
        rdn_d  = rdn_q;
        rdd_d  = rdd_q;
        busy_d = busy_q;
        if (alu_grant_s) begin
            last_d = GRANT_ALU;
            wbe_d  = (alu_rd != 5'd0);
            rdn_d  = alu_rd;
            rdd_d  = alu_data;
        end else if (lsu_grant_s) begin
            last_d = GRANT_LSU;
            wbe_d  = (lsu_rd != 5'd0);
            rdn_d  = lsu_rd;
            rdd_d  = lsu_data;
            busy_d[lsu_rd] = 1'b0;
        end else begin
            wbe_d = 1'b0;
        end
        // Applied after the clear so a same-edge issue keeps the register pending
        if (issue_en && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= GRANT_LSU;
            wbe_q  <= 1'b0;
            rdn_q  <= 5'd0;
            rdd_q  <= {WordSize{1'b0}};
            busy_q <= 32'd0;
        end else begin
            last_q <= last_d;
            wbe_q  <= wbe_d;
            rdn_q  <= rdn_d;
            rdd_q  <= rdd_d;
            busy_q <= busy_d;
        end
    end

    assign wbe   = wbe_q;
    assign rdn   = rdn_q;
    assign rdd   = rdd_q;
    assign stall = busy_q[chk_rs1n] | busy_q[chk_rs2n] | busy_q[chk_rdn];

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Bench for gpr_wb_arbiter: directed scenarios with literal expectations plus a
// behavioural scoreboard checked against the DUT on every falling clock edge.
module tb_gpr_wb_arbiter;

    logic        clk = 1'b0;
    logic        rstn;
    logic        alu_valid, lsu_valid, issue_en;
    logic [4:0]  alu_rd, lsu_rd, issue_rd, chk_rs1n, chk_rs2n, chk_rdn;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready, stall, wbe;
    logic [4:0]  rdn;
    logic [31:0] rdd;

    int n_cmp = 0;
    int n_fail = 0;

    // Model state: last winner (1=ALU, 2=LSU), pending set, expected write port
    int          m_last;
    bit [31:0]   m_busy;
    bit          m_wbe;
    bit [4:0]    m_rdn;
    bit [31:0]   m_rdd;

    gpr_wb_arbiter #(.WordSize(32)) dut (
        .clk(clk), .rstn(rstn),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .issue_en(issue_en), .issue_rd(issue_rd),
        .chk_rs1n(chk_rs1n), .chk_rs2n(chk_rs2n), .chk_rdn(chk_rdn),
        .stall(stall), .wbe(wbe), .rdn(rdn), .rdd(rdd)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Who should win given the requests and the previous winner
    function automatic int pick(input logic av, input logic lv, input int last);
        if (av && lv) return (last == 2) ? 1 : 2;
        if (av) return 1;
        if (lv) return 2;
        return 0;
    endfunction

    // Behavioural model update
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_last <= 2;
            m_busy <= 32'd0;
            m_wbe  <= 1'b0;
            m_rdn  <= 5'd0;
            m_rdd  <= 32'd0;
        end else begin
            m_wbe <= 1'b0;
            if (pick(alu_valid, lsu_valid, m_last) == 1) begin
                m_last <= 1;
                m_wbe  <= (alu_rd != 5'd0);
                m_rdn  <= alu_rd;
                m_rdd  <= alu_data;
            end else if (pick(alu_valid, lsu_valid, m_last) == 2) begin
                m_last <= 2;
                m_wbe  <= (lsu_rd != 5'd0);
                m_rdn  <= lsu_rd;
                m_rdd  <= lsu_data;
                m_busy[lsu_rd] <= 1'b0;
            end
            if (issue_en && issue_rd != 5'd0) m_busy[issue_rd] <= 1'b1;
        end
    end

    // Compare process
    always @(negedge clk) begin
        check("cmp_alu_ready", 32'(alu_ready), 32'(pick(alu_valid, lsu_valid, m_last) == 1));
        check("cmp_lsu_ready", 32'(lsu_ready), 32'(pick(alu_valid, lsu_valid, m_last) == 2));
        check("cmp_stall", 32'(stall), 32'(m_busy[chk_rs1n] | m_busy[chk_rs2n] | m_busy[chk_rdn]));
        check("cmp_wbe", 32'(wbe), 32'(m_wbe));
        if (m_wbe) begin
            check("cmp_rdn", 32'(rdn), 32'(m_rdn));
            check("cmp_rdd", rdd, m_rdd);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; lsu_valid = 1'b0; issue_en = 1'b0;
        alu_rd = 5'd0; lsu_rd = 5'd0; issue_rd = 5'd0;
        alu_data = 32'd0; lsu_data = 32'd0;
        chk_rs1n = 5'd0; chk_rs2n = 5'd0; chk_rdn = 5'd0;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1 rstn = 1'b0;
        #2 rstn = 1'b1;
    endtask

    initial begin
        idle();
        rstn = 1'b0;
        #1;
        check("rst_wbe", 32'(wbe), 32'd0);
        check("rst_rdn", 32'(rdn), 32'd0);
        check("rst_rdd", rdd, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Single ALU write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        @(negedge clk);
        check("alu_only_ready", 32'(alu_ready), 32'd1);
        step();
        idle();
        @(negedge clk);
        check("alu_only_wbe", 32'(wbe), 32'd1);
        check("alu_only_rdn", 32'(rdn), 32'd5);
        check("alu_only_rdd", rdd, 32'hDEADBEEF);
        step();
        @(negedge clk);
        check("alu_only_wbe_drop", 32'(wbe), 32'd0);

        // Round-robin after fresh reset: ALU, LSU, ALU, LSU
        reset_pulse();
        step();
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1111_0001;
        lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2222_0002;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_alu_ready", 32'(alu_ready), 32'((i % 2) == 0));
            check("rr_lsu_ready", 32'(lsu_ready), 32'((i % 2) == 1));
            if (i > 0) check("rr_rdn", 32'(rdn), ((i % 2) == 1) ? 32'd1 : 32'd2);
            step();
        end
        idle();
        @(negedge clk);
        check("rr_rdn_last", 32'(rdn), 32'd2);
        check("rr_rdd_last", rdd, 32'h2222_0002);

        // Scoreboard set and clear
        issue_en = 1'b1; issue_rd = 5'd7;
        step();
        issue_en = 1'b0; chk_rs1n = 5'd7; chk_rs2n = 5'd0;
        @(negedge clk);
        check("sb_stall_set", 32'(stall), 32'd1);
        step();
        chk_rs1n = 5'd0;
        @(negedge clk);
        check("sb_rs2_zero", 32'(stall), 32'd0);
        step();
        chk_rs1n = 5'd7;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h0000_0777;
        @(negedge clk);
        check("sb_stall_before_edge", 32'(stall), 32'd1);
        step();
        lsu_valid = 1'b0;
        @(negedge clk);
        check("sb_stall_cleared", 32'(stall), 32'd0);
        check("sb_wbe", 32'(wbe), 32'd1);
        check("sb_rdn", 32'(rdn), 32'd7);

        // Same-edge set and clear: set wins
        step();
        issue_en = 1'b1; issue_rd = 5'd9;
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h0000_0999;
        step();
        idle();
        chk_rdn = 5'd9;
        @(negedge clk);
        check("setclr_stall", 32'(stall), 32'd1);
        check("setclr_wbe", 32'(wbe), 32'd1);
        check("setclr_rdn", 32'(rdn), 32'd9);

        // rd=0 accepted but not written
        step();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234_5678;
        @(negedge clk);
        check("rd0_ready", 32'(alu_ready), 32'd1);
        step();
        idle();
        @(negedge clk);
        check("rd0_wbe", 32'(wbe), 32'd0);

        // Asynchronous reset mid-cycle
        step();
        issue_en = 1'b1; issue_rd = 5'd3;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hCAFE_F00D;
        step();
        idle();
        chk_rs1n = 5'd3;
        #1;
        check("arst_pre_wbe", 32'(wbe), 32'd1);
        check("arst_pre_stall", 32'(stall), 32'd1);
        rstn = 1'b0;
        #1;
        check("arst_wbe", 32'(wbe), 32'd0);
        check("arst_rdn", 32'(rdn), 32'd0);
        check("arst_rdd", rdd, 32'd0);
        check("arst_stall", 32'(stall), 32'd0);
        step();
        rstn = 1'b1;

        // Mixed traffic against the model
        for (int i = 0; i < 60; i++) begin
            alu_valid = 1'($urandom_range(0, 1));
            lsu_valid = 1'($urandom_range(0, 1));
            issue_en  = 1'($urandom_range(0, 1));
            alu_rd    = 5'($urandom_range(0, 7));
            lsu_rd    = 5'($urandom_range(0, 7));
            issue_rd  = 5'($urandom_range(0, 7));
            alu_data  = $urandom;
            lsu_data  = $urandom;
            chk_rs1n  = 5'($urandom_range(0, 7));
            chk_rs2n  = 5'($urandom_range(0, 7));
            chk_rdn   = 5'($urandom_range(0, 7));
            step();
        end
        idle();
        step();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
